rgb_led_arbiter: RTL and testbench
==================================

# rgb_led_arbiter

Shares the on-board RGB LED driver between two requesters: a low-priority status source and a high-priority alert source. Generates the three PWM drive signals and the driver enable for the RGB driver primitive. Arbitrates ownership only on PWM frame boundaries, so the visible colour never glitches mid-frame. Sits between the application logic and the RGB driver instance, in the internal-oscillator clock domain.

## Interface
- PWM_BITS, 8, PWM counter and duty width; frame = 2^PWM_BITS ticks
- PRESCALE, 4, clock cycles per PWM tick (>=1)
- MIN_HOLD, 16, minimum frames req0 keeps ownership before req1 may preempt (>=1)

- clk  in  1  single clock (internal oscillator)
- rst  in  1  synchronous, active-high reset
- req  in  2  request; bit1 = alert (high priority), bit0 = status
- color0  in  3*PWM_BITS  requester 0 duties {r,g,b}, r in MSBs
- color1  in  3*PWM_BITS  requester 1 duties {r,g,b}
- gnt  out  2  one-hot ownership, 00 when idle
- led_en  out  1  driver enable; 1 while any requester owns
- pwm_r, pwm_g, pwm_b  out  1  PWM drive to RGB driver channels
- frame_start  out  1  one-cycle pulse on the cycle the PWM counter is 0 after a wrap

## Operation
- Prescaler pre: counts 0..PRESCALE-1, wraps; tick = (pre == PRESCALE-1).
- PWM counter cnt (PWM_BITS): increments on tick, wraps max→0 (modulo 2^PWM_BITS).
- Boundary event B = tick && cnt == all-ones. All arbitration and duty loads occur only on the B edge.
- States: IDLE, OWN0, OWN1. Reset → IDLE.
- At B, from IDLE: req[1] → OWN1; else req[0] → OWN0; else stay. Both set → OWN1.
- At B, from OWN1: req[1] low → (req[0] ? OWN0 : IDLE); else stay.
- At B, from OWN0: req[0] low → (req[1] ? OWN1 : IDLE); req[1] high and hold == MIN_HOLD → OWN1; else stay.
- hold counter: cleared to 0 on entry to any OWN state, +1 at each B while owning, saturates at MIN_HOLD.
- Duty shadows dr/dg/db load at B from next owner's color; load 0 when next state IDLE. Colour inputs outside B are ignored.
- Requester dropping req mid-frame keeps gnt and colour until next B.
- gnt = {state==OWN1, state==OWN0}; led_en = (state != IDLE); both registered.
- pwm_x registered: pwm_x <= (cnt < dx) each cycle. Duty 0 → constant 0; duty 2^PWM_BITS-1 → high 255 of 256 ticks (at default width); 100 % is not reachable.
- frame_start registered: asserted the cycle after B (cnt now 0), one cycle wide.

## Timing
- Reset (sync, any cycle, including mid-frame or while owning): next edge pre=0, cnt=0, state IDLE, hold=0, duties 0; all outputs 0 (gnt=00, led_en=0, pwm_*=0, frame_start=0).
- Frame length = PRESCALE*2^PWM_BITS cycles (1024 at defaults).
- Grant latency: req rising → gnt on the B edge ending the current frame; worst case one frame + 1 cycle. Requests must be held until granted; a req pulse not present at B is lost.
- gnt, led_en, frame_start, duty shadows all change on the same B edge; pwm_* reflects new duty one cycle later (first cycle of new frame).
- pwm_* has one cycle latency from cnt; per-frame high time = duty*PRESCALE cycles exactly.
- Preemption of OWN0 by req[1]: earliest at the MIN_HOLD-th B after OWN0 entry.

## Test plan
- Reset mid-frame while OWN1 with color1=FF_FF_FF: rst high one cycle → next cycle all outputs 0, state IDLE; counting restarts from pre=0, cnt=0.
- req=01, color0=0x40_00_FF, defaults: gnt=01 and led_en=1 at first B; each frame pwm_r high 256 cycles, pwm_g 0, pwm_b 1020 cycles; frame_start every 1024 cycles.
- req=11 from IDLE: gnt=10 at first B; color1 loaded, color0 ignored.
- req0 owning, req1 raised 2 frames after grant, MIN_HOLD=16: gnt stays 01 until the 16th B after OWN0 entry, then gnt=10 on that edge.
- Owner drops req mid-frame, other req low: gnt held to frame end, then gnt=00, led_en=0, pwm_* 0 thereafter.
- color0 changed mid-frame from 0x10 to 0x80 red: current frame red high 64 cycles, next frame 512 cycles; no intermediate value.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rgb_led_arbiter : two-requester RGB LED PWM owner, switches on frame end  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rgb_led_arbiter #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 4,
  parameter int MIN_HOLD = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req,
  input  logic [3*PWM_BITS-1:0]   color0,
  input  logic [3*PWM_BITS-1:0]   color1,
  output logic [1:0]              gnt,
  output logic                    led_en,
  output logic                    pwm_r,
  output logic                    pwm_g,
  output logic                    pwm_b,
  output logic                    frame_start
);

  localparam int                PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int                HOLD_W   = $clog2(MIN_HOLD + 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   hold_inc;
  logic [PWM_BITS-1:0] dr_q, dr_d, dg_q, dg_d, db_q, db_d;
  logic [1:0]          gnt_q, gnt_d;
  logic                led_en_q, led_en_d;
  logic                pwm_r_q, pwm_r_d, pwm_g_q, pwm_g_d, pwm_b_q, pwm_b_d;
  logic                frame_start_q, frame_start_d;
  logic                tick;
  logic                boundary;

  always_comb begin
    tick     = (pre_q == PRE_MAX);
    boundary = tick && (&cnt_q);
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    cnt_d    = tick ? cnt_q + PWM_BITS'(1) : cnt_q;
    hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);

    state_d = state_q;
    hold_d  = hold_q;
    dr_d    = dr_q;
    dg_d    = dg_q;
    db_d    = db_q;

    if (boundary) begin
      case (state_q)
        ST_IDLE: begin
          if (req[1])      state_d = ST_OWN1;
          else if (req[0]) state_d = ST_OWN0;
        end
        ST_OWN1: begin
          if (!req[1]) state_d = req[0] ? ST_OWN0 : ST_IDLE;
        end
        ST_OWN0: begin
          // hold_inc counts frames owned including the one ending now, so
          // the alert can take over at the MIN_HOLD-th boundary after entry
          if (!req[0])                           state_d = req[1] ? ST_OWN1 : ST_IDLE;
          else if (req[1] && hold_inc == HOLD_MAX) state_d = ST_OWN1;
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_d != state_q)   hold_d = '0;
      else if (state_q != ST_IDLE) hold_d = hold_inc;

      case (state_d)
        ST_OWN0: begin
          dr_d = color0[3*PWM_BITS-1 -: PWM_BITS];
          dg_d = color0[2*PWM_BITS-1 -: PWM_BITS];
          db_d = color0[PWM_BITS-1:0];
        end
        ST_OWN1: begin
          dr_d = color1[3*PWM_BITS-1 -: PWM_BITS];
          dg_d = color1[2*PWM_BITS-1 -: PWM_BITS];
          db_d = color1[PWM_BITS-1:0];
        end
        default: begin
          dr_d = '0;
          dg_d = '0;
          db_d = '0;
        end
      endcase
    end

    gnt_d         = {state_d == ST_OWN1, state_d == ST_OWN0};
    led_en_d      = (state_d != ST_IDLE);
    pwm_r_d       = (cnt_q < dr_q);
    pwm_g_d       = (cnt_q < dg_q);
    pwm_b_d       = (cnt_q < db_q);
    frame_start_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pre_q         <= '0;
      cnt_q         <= '0;
      hold_q        <= '0;
      dr_q          <= '0;
      dg_q          <= '0;
      db_q          <= '0;
      gnt_q         <= '0;
      led_en_q      <= 1'b0;
      pwm_r_q       <= 1'b0;
      pwm_g_q       <= 1'b0;
      pwm_b_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      dr_q          <= dr_d;
      dg_q          <= dg_d;
      db_q          <= db_d;
      gnt_q         <= gnt_d;
      led_en_q      <= led_en_d;
      pwm_r_q       <= pwm_r_d;
      pwm_g_q       <= pwm_g_d;
      pwm_b_q       <= pwm_b_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign gnt         = gnt_q;
  assign led_en      = led_en_q;
  assign pwm_r       = pwm_r_q;
  assign pwm_g       = pwm_g_q;
  assign pwm_b       = pwm_b_q;
  assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_rgb_led_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_rgb_led_arbiter : frame-level vectors plus multi-frame corner cases    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_rgb_led_arbiter;

  localparam int FRAME = 1024;

  typedef struct {
    logic [1:0]  req;
    logic [23:0] c0;
    logic [23:0] c1;
    logic [1:0]  gnt;
    logic        led;
    int          r;
    int          g;
    int          b;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [23:0] color0, color1;
  logic [1:0]  gnt;
  logic        led_en, pwm_r, pwm_g, pwm_b, frame_start;

  int errors = 0;
  int checks = 0;

  rgb_led_arbiter #(.PWM_BITS(8), .PRESCALE(4), .MIN_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .color0(color0), .color1(color1),
    .gnt(gnt), .led_en(led_en), .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // advance to the next frame_start cycle strictly after the current one
  task automatic wait_frame(input string name);
    for (int i = 0; i < FRAME + 16; i++) begin
      @(negedge clk);
      if (frame_start) return;
    end
    check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // count pwm high cycles over one frame starting after a frame_start cycle;
  // ends on the following frame_start cycle
  task automatic measure(input int chg_at, input logic [23:0] chg_c0,
                         output int r, output int g, output int b,
                         output int fs_cnt, output logic fs_end);
    r = 0; g = 0; b = 0; fs_cnt = 0; fs_end = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      r += int'(pwm_r);
      g += int'(pwm_g);
      b += int'(pwm_b);
      if (frame_start) fs_cnt++;
      if (i == FRAME) fs_end = frame_start;
      if (i == chg_at) color0 = chg_c0;
    end
  endtask

  vec_t vecs[8];

  initial begin
    int r, g, b, fs_cnt, first_fs;
    logic fs_end;

    vecs[0] = '{req: 2'b00, c0: 24'h40_00_FF, c1: 24'hFF_FF_FF, gnt: 2'b00, led: 1'b0, r: 0,   g: 0,    b: 0};
    vecs[1] = '{req: 2'b11, c0: 24'h40_00_FF, c1: 24'h01_80_FF, gnt: 2'b10, led: 1'b1, r: 4,   g: 512,  b: 1020};
    vecs[2] = '{req: 2'b10, c0: 24'h40_00_FF, c1: 24'h00_FF_20, gnt: 2'b10, led: 1'b1, r: 0,   g: 1020, b: 128};
    vecs[3] = '{req: 2'b01, c0: 24'h40_00_FF, c1: 24'hFF_FF_FF, gnt: 2'b01, led: 1'b1, r: 256, g: 0,    b: 1020};
    vecs[4] = '{req: 2'b01, c0: 24'h10_20_30, c1: 24'hFF_FF_FF, gnt: 2'b01, led: 1'b1, r: 64,  g: 128,  b: 192};
    vecs[5] = '{req: 2'b00, c0: 24'hFF_FF_FF, c1: 24'hFF_FF_FF, gnt: 2'b00, led: 1'b0, r: 0,   g: 0,    b: 0};
    vecs[6] = '{req: 2'b10, c0: 24'h11_11_11, c1: 24'h80_80_80, gnt: 2'b10, led: 1'b1, r: 512, g: 512,  b: 512};
    vecs[7] = '{req: 2'b00, c0: 24'h11_11_11, c1: 24'h80_80_80, gnt: 2'b00, led: 1'b0, r: 0,   g: 0,    b: 0};

    rst = 1'b1; req = 2'b00; color0 = '0; color1 = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_led_en", 32'(led_en), 32'd0);
    check("rst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req = vecs[i].req; color0 = vecs[i].c0; color1 = vecs[i].c1;
      wait_frame($sformatf("v%0d", i));
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      check($sformatf("v%0d_led_en", i), 32'(led_en), 32'(vecs[i].led));
      measure(0, 24'h0, r, g, b, fs_cnt, fs_end);
      check($sformatf("v%0d_r_high", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("v%0d_g_high", i), 32'(g), 32'(vecs[i].g));
      check($sformatf("v%0d_b_high", i), 32'(b), 32'(vecs[i].b));
      check($sformatf("v%0d_frame_period", i), 32'({fs_cnt[7:0], 7'd0, fs_end}), 32'h101);
    end

    // preemption of a status owner by the alert after the minimum hold
    req = 2'b01; color0 = 24'h40_00_FF; color1 = 24'h20_00_00;
    wait_frame("pre_entry");
    check("pre_entry_gnt", 32'(gnt), 32'b01);
    for (int k = 1; k <= 16; k++) begin
      wait_frame($sformatf("pre_b%0d", k));
      check($sformatf("pre_b%0d_gnt", k), 32'(gnt), (k < 16) ? 32'b01 : 32'b10);
      if (k == 2) req = 2'b11;
    end
    measure(0, 24'h0, r, g, b, fs_cnt, fs_end);
    check("pre_color1_r", 32'(r), 32'd128);

    // owner drops mid-frame, nobody else requesting
    req = 2'b10;
    repeat (300) @(negedge clk);
    req = 2'b00;
    repeat (5) @(negedge clk);
    check("drop_gnt_held", 32'(gnt), 32'b10);
    check("drop_led_held", 32'(led_en), 32'd1);
    wait_frame("drop");
    check("drop_gnt_idle", 32'(gnt), 32'b00);
    check("drop_led_off", 32'(led_en), 32'd0);
    measure(0, 24'h0, r, g, b, fs_cnt, fs_end);
    check("drop_pwm_off", 32'(r + g + b), 32'd0);

    // colour change mid-frame only takes effect at the next boundary
    req = 2'b01; color0 = 24'h10_00_00;
    wait_frame("col");
    check("col_gnt", 32'(gnt), 32'b01);
    measure(100, 24'h80_00_00, r, g, b, fs_cnt, fs_end);
    check("col_old_r", 32'(r), 32'd64);
    measure(0, 24'h0, r, g, b, fs_cnt, fs_end);
    check("col_new_r", 32'(r), 32'd512);

    // reset mid-frame while the alert owns a full-white colour
    req = 2'b10; color1 = 24'hFF_FF_FF;
    wait_frame("mrst");
    check("mrst_own_gnt", 32'(gnt), 32'b10);
    repeat (500) @(negedge clk);
    rst = 1'b1; req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_gnt", 32'(gnt), 32'd0);
    check("mrst_led_en", 32'(led_en), 32'd0);
    check("mrst_pwm", 32'({pwm_r, pwm_g, pwm_b}), 32'd0);
    check("mrst_frame_start", 32'(frame_start), 32'd0);
    first_fs = 0;
    for (int i = 1; i <= FRAME + 8; i++) begin
      @(negedge clk);
      if (frame_start && first_fs == 0) first_fs = i;
    end
    check("mrst_restart_period", 32'(first_fs), 32'(FRAME));
    check("mrst_idle_gnt", 32'(gnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
